// File: rtl/snn_pkg.sv
// Shared constants and helpers for the spiking-network datapath blocks.
package snn_pkg;

    localparam int SPIKE_ID_W         = 8;
    localparam int DEFAULT_NUM_SRC    = 4;
    localparam int DEFAULT_LOCAL_ID_W = 6;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Usable in constant expressions (parameter/localparam derivation).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: rotate requests so ptr is bit 0,
// pick the lowest set bit, then rotate the result back.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;
    logic             found;

    assign doubled = {req, req} >> ptr;
    assign rotated = doubled[N-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = i[IDX_W-1:0];
            end
        end
    end

    // N is a power of two, so the IDX_W-bit add wraps modulo N for free.
    assign index = ptr + offset;
    assign grant = found ? ({{(N-1){1'b0}}, 1'b1} << index) : '0;

endmodule

// File: rtl/spike_out_arbiter.sv
// Merges spikes from NUM_SRC neuron clusters into one registered output
// entry tagged {source, local id}, and counts accepted output spikes.
module spike_out_arbiter
    import snn_pkg::*;
#(
    parameter int NUM_SRC    = DEFAULT_NUM_SRC,
    parameter int LOCAL_ID_W = DEFAULT_LOCAL_ID_W
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic                          count_clear,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*LOCAL_ID_W-1:0] src_neuron_id,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          spike_out_valid,
    output logic [clog2(NUM_SRC)+LOCAL_ID_W-1:0] spike_out_neuron_id,
    input  logic                          spike_out_ready,
    output logic [31:0]                   spike_count,
    output logic                          busy
);

    localparam int SRC_W = clog2(NUM_SRC);

    logic                  load_ok;
    logic                  handshake;
    logic [NUM_SRC-1:0]    gated_req;
    logic [NUM_SRC-1:0]    grant;
    logic [SRC_W-1:0]      grant_idx;
    logic [SRC_W-1:0]      rr_ptr;
    logic [LOCAL_ID_W-1:0] grant_local_id;

    assign load_ok   = !spike_out_valid || spike_out_ready;
    assign handshake = spike_out_valid && spike_out_ready;
    assign gated_req = (enable && load_ok) ? src_valid : '0;

    rr_grant #(
        .N     (NUM_SRC),
        .IDX_W (SRC_W)
    ) u_rr_grant (
        .req   (gated_req),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (grant_idx)
    );

    assign src_ready      = grant;
    assign grant_local_id = src_neuron_id[grant_idx*LOCAL_ID_W +: LOCAL_ID_W];
    assign busy           = spike_out_valid || (|src_valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            spike_out_valid     <= 1'b0;
            spike_out_neuron_id <= '0;
            rr_ptr              <= '0;
        end else if (|grant) begin
            // A load may coincide with a drain, giving one spike per cycle.
            spike_out_valid     <= 1'b1;
            spike_out_neuron_id <= {grant_idx, grant_local_id};
            rr_ptr              <= grant_idx + 1'b1;
        end else if (handshake) begin
            spike_out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            spike_count <= '0;
        end else if (count_clear) begin
            spike_count <= '0;
        end else if (handshake && (spike_count != COUNT_MAX)) begin
            spike_count <= spike_count + 32'd1;
        end
    end

endmodule

// File: doc/spike_out_arbiter.md
Name: spike_out_arbiter

Overview:
- Round-robin arbiter that merges spike outputs from NUM_SRC neuron clusters into the single spike_out valid/ready/neuron_id port of the AXI-Stream output path.
- Forms the global neuron ID as {source index, local ID}.
- Holds one registered output entry.
- Maintains the saturating 32-bit spike counter exported to the status register map.

Parameters:
- NUM_SRC, 4, number of requesting neuron clusters (power of 2, 2..16).
- LOCAL_ID_W, 6, local neuron ID width per cluster.
- SRC_W, derived localparam = clog2(NUM_SRC), source index width; not overridable.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- enable  in  1  arbitration enable (from ctrl_reg bit 0).
- count_clear  in  1  synchronous clear of spike_count.
- src_valid  in  NUM_SRC  per-cluster spike request.
- src_neuron_id  in  NUM_SRC*LOCAL_ID_W  packed local IDs; source i occupies bits [i*LOCAL_ID_W +: LOCAL_ID_W].
- src_ready  out  NUM_SRC  per-cluster grant/accept (combinational).
- spike_out_valid  out  1  output entry valid.
- spike_out_neuron_id  out  SRC_W+LOCAL_ID_W  global ID {src, local}.
- spike_out_ready  in  1  downstream accept.
- spike_count  out  32  accepted output spikes, saturating.
- busy  out  1  spike_out_valid OR any src_valid.

Behaviour:
- Reset (async, immediate) clears: spike_out_valid=0, spike_out_neuron_id=0, rr_ptr=0 (source 0 highest priority), spike_count=0. A pending entry is discarded.
- load_ok = !spike_out_valid || spike_out_ready.
- Grant is a combinational one-hot over src_valid, gated by enable && load_ok.
  - Search order starts at rr_ptr and wraps modulo NUM_SRC.
  - At most one bit set; src_ready = grant.
- On a clock edge with grant[i]=1:
  - spike_out_valid<=1.
  - spike_out_neuron_id<={i[SRC_W-1:0], local_id_i}.
  - rr_ptr<=(i+1) mod NUM_SRC.
- Without a grant: if spike_out_valid && spike_out_ready, then spike_out_valid<=0; otherwise hold. Entry data is stable while valid and not ready.
- Latency: request to spike_out_valid is 1 cycle. Throughput is 1 spike/cycle when spike_out_ready stays high (simultaneous drain and load).
- rr_ptr is unchanged when there is no grant, including when enable=0.
- enable=0: no new grants and src_ready=0. An already-held entry still drains normally.
- spike_count:
  - Increments on spike_out_valid && spike_out_ready.
  - Saturates at 32'hFFFFFFFF with no wrap.
  - count_clear has priority: clear and handshake in the same cycle yields 0.
- Source protocol: a source holds src_valid and its ID stable until it sees src_ready. The arbiter never drops an accepted spike.
- All src_valid low: no grant, rr_ptr unchanged. busy follows the port definition combinationally.

Decomposition:
- Shared package snn_pkg holds:
  - SPIKE_ID_W = 8.
  - Default NUM_SRC and LOCAL_ID_W.
  - Function clog2.
  - COUNT_MAX constant.
- One natural sub-module, rr_grant: purely combinational rotate/priority-encode/rotate-back.
  - Inputs: req, ptr.
  - Outputs: one-hot grant and binary index.
  - Reusable for future weight-memory port arbitration.
- Output register, pointer and counter stay in spike_out_arbiter.

Test Plan:
- Reset, then src_valid=4'b0001 with src0 ID 6'h05 held one cycle, ready=1 -> src_ready=0001 that cycle; next cycle spike_out_valid=1, ID=8'h05; spike_count=1 after the handshake.
- src_valid=4'b1111 held, all IDs=6'h3F, ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; output IDs 3F,7F,BF,FF repeating; one spike per cycle; spike_count=8.
- Output backpressure: load src2 ID 6'h0A, spike_out_ready=0 for 5 cycles while src1 is valid -> spike_out_neuron_id stays 8'h8A; src_ready=0 throughout; on ready=1, the same edge loads src1 (ID 8'h4x) with no bubble.
- enable=0 with src_valid=4'b0110 -> src_ready=0 and rr_ptr frozen; re-enable -> src1 is granted first.
- count_clear asserted in the same cycle as a handshake, with spike_count=10 -> spike_count=0. Separately, force spike_count to FFFFFFFE, then 3 handshakes -> FFFFFFFF held.
- Assert areset mid-burst while the output is valid and not ready -> spike_out_valid=0 and spike_count=0 immediately, without waiting for a clock edge; after release, source 0 has priority.
